// File: rtl/alu_writeback.sv
// alu_writeback: the stage directly after the ALU. It owns the architectural
// state: a NREG x XLEN register file, the F1/F2 condition flags, the program
// counter and a retired-beat counter.
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   valid_in           an ALU beat is present this cycle
//   instr, dest        opcode and destination index of the beat
//   C, F3              ALU result and condition output
//   addrch, naddr      ALU branch-taken flag and branch target
//   rs_a, rs_b         operand read indices
//   rd_a, rd_b, reg8   combinational reads (with same-cycle write bypass)
//   F1, F2             newest / previous condition flags
//   pc                 current program counter
//   flushing           high during the single cycle after a redirect
//   retired            count of committed beats (wraps at 2^32)
module alu_writeback #(
  parameter int              XLEN     = 64,
  parameter int              NREG     = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              LINK_REG = 15
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    valid_in,
  input  logic [5:0]              instr,
  input  logic [$clog2(NREG)-1:0] dest,
  input  logic [XLEN-1:0]         C,
  input  logic                    F3,
  input  logic                    addrch,
  input  logic [XLEN-1:0]         naddr,
  input  logic [$clog2(NREG)-1:0] rs_a,
  input  logic [$clog2(NREG)-1:0] rs_b,
  output logic [XLEN-1:0]         rd_a,
  output logic [XLEN-1:0]         rd_b,
  output logic [XLEN-1:0]         reg8,
  output logic                    F1,
  output logic                    F2,
  output logic [XLEN-1:0]         pc,
  output logic                    flushing,
  output logic [31:0]             retired
);

  localparam int              IDX_W    = $clog2(NREG);
  localparam logic [IDX_W-1:0] LINK_IDX = IDX_W'(LINK_REG);
  localparam logic [IDX_W-1:0] R8_IDX   = IDX_W'(8);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   regs_q [NREG];
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              f1_q, f1_d, f2_q, f2_d;
  logic [31:0]       retired_q, retired_d;

  logic              accept;
  logic              redirect;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [XLEN-1:0]   wr_data;
  logic [XLEN-1:0]   pc_plus1;

  function automatic logic op_writes(input logic [5:0] op);
    return (op <= 6'd7) || (op == 6'd16) || (op == 6'd17);
  endfunction

  function automatic logic op_flags(input logic [5:0] op);
    return (op >= 6'd8) && (op <= 6'd13);
  endfunction

  // Beat decode and write-port selection
  always_comb begin
    accept   = valid_in && (state_q == RUN);
    pc_plus1 = pc_q + XLEN'(1);
    redirect = accept && (addrch || (instr == 6'd6) || (instr == 6'd7));
    wr_en    = accept && op_writes(instr);
    // A call writes the return address into the link register, ignoring C
    wr_idx   = (instr == 6'd7) ? LINK_IDX : dest;
    wr_data  = (instr == 6'd7) ? pc_plus1 : C;
  end

  // Next-state logic: FLUSH always lasts exactly one cycle
  always_comb begin
    state_d   = RUN;
    pc_d      = pc_q;
    f1_d      = f1_q;
    f2_d      = f2_q;
    retired_d = retired_q;
    if (accept) begin
      retired_d = retired_q + 32'd1;
      pc_d      = redirect ? naddr : pc_plus1;
      if (op_flags(instr)) begin
        f2_d = f1_q;
        f1_d = F3;
      end
    end
    if (redirect) state_d = FLUSH;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      f1_q      <= 1'b0;
      f2_q      <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      f1_q      <= f1_d;
      f2_q      <= f2_d;
      retired_q <= retired_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wr_idx] <= wr_data;
    end
  end

  // Read ports: forward the in-flight write so the ALU sees it this cycle
  always_comb begin
    rd_a = (wr_en && (wr_idx == rs_a))   ? wr_data : regs_q[rs_a];
    rd_b = (wr_en && (wr_idx == rs_b))   ? wr_data : regs_q[rs_b];
    reg8 = (wr_en && (wr_idx == R8_IDX)) ? wr_data : regs_q[R8_IDX];
  end

  assign F1       = f1_q;
  assign F2       = f2_q;
  assign pc       = pc_q;
  assign flushing = (state_q == FLUSH);
  assign retired  = retired_q;

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [5:0]  instr;
  logic [3:0]  dest;
  logic [63:0] C;
  logic        F3;
  logic        addrch;
  logic [63:0] naddr;
  logic [3:0]  rs_a;
  logic [3:0]  rs_b;
  logic [63:0] rd_a, rd_b, reg8, pc;
  logic        F1, F2, flushing;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  alu_writeback dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .instr(instr),
    .dest(dest), .C(C), .F3(F3), .addrch(addrch), .naddr(naddr),
    .rs_a(rs_a), .rs_b(rs_b), .rd_a(rd_a), .rd_b(rd_b), .reg8(reg8),
    .F1(F1), .F2(F2), .pc(pc), .flushing(flushing), .retired(retired)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [5:0] op, input logic [3:0] d, input logic [63:0] c,
                      input logic f3, input logic ach, input logic [63:0] na);
    valid_in = 1'b1;
    instr    = op;
    dest     = d;
    C        = c;
    F3       = f3;
    addrch   = ach;
    naddr    = na;
  endtask

  task automatic idle();
    valid_in = 1'b0;
    addrch   = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    valid_in = 1'b0; instr = '0; dest = '0; C = '0; F3 = 1'b0;
    addrch = 1'b0; naddr = '0; rs_a = '0; rs_b = '0;
    #12;
    chk("rst_pc", pc, 64'h0);
    chk("rst_flags", 64'({F1, F2}), 64'h0);
    chk("rst_flush", 64'(flushing), 64'h0);
    chk("rst_retired", 64'(retired), 64'h0);
    chk("rst_reg", rd_a, 64'h0);
    @(negedge clock);
    reset = 1'b0;
    step();

    // Test 1: simple write plus same-cycle bypass
    beat(6'd0, 4'd3, 64'h1234, 1'b0, 1'b0, 64'h0);
    rs_a = 4'd3;
    #1;
    chk("t1_bypass", rd_a, 64'h1234);
    step();
    idle();
    #1;
    chk("t1_reg3", rd_a, 64'h1234);
    chk("t1_pc", pc, 64'h1);
    chk("t1_retired", 64'(retired), 64'h1);

    // Test 2: flag shifting
    beat(6'd8, 4'd0, 64'h0, 1'b1, 1'b0, 64'h0);
    step();
    idle();
    chk("t2_flags_a", 64'({F1, F2}), 64'b10);
    beat(6'd9, 4'd0, 64'h0, 1'b0, 1'b0, 64'h0);
    step();
    idle();
    chk("t2_flags_b", 64'({F1, F2}), 64'b01);
    beat(6'd0, 4'd1, 64'h0, 1'b1, 1'b0, 64'h0);
    step();
    idle();
    chk("t2_flags_hold", 64'({F1, F2}), 64'b01);

    // Test 3: branch on a non-writing opcode, following beat dropped
    beat(6'd15, 4'd0, 64'h0, 1'b0, 1'b1, 64'h40);
    step();
    chk("t3_pc", pc, 64'h40);
    chk("t3_flush", 64'(flushing), 64'h1);
    chk("t3_retired", 64'(retired), 64'h5);
    beat(6'd0, 4'd2, 64'h55, 1'b0, 1'b0, 64'h0);
    rs_b = 4'd2;
    #1;
    chk("t3_nobypass", rd_b, 64'h0);
    step();
    idle();
    #1;
    chk("t3_run", 64'(flushing), 64'h0);
    chk("t3_pc_hold", pc, 64'h40);
    chk("t3_ret_hold", 64'(retired), 64'h5);
    chk("t3_reg2", rd_b, 64'h0);

    // Test 4: call from pc 0x10
    beat(6'd15, 4'd0, 64'h0, 1'b0, 1'b1, 64'h10);
    step();
    idle();
    step();
    chk("t4_pc_pre", pc, 64'h10);
    beat(6'd7, 4'd1, 64'hDEAD, 1'b0, 1'b0, 64'h80);
    rs_a = 4'd15;
    #1;
    chk("t4_link_bypass", rd_a, 64'h11);
    step();
    idle();
    #1;
    chk("t4_link", rd_a, 64'h11);
    chk("t4_pc", pc, 64'h80);
    chk("t4_flush", 64'(flushing), 64'h1);
    chk("t4_retired", 64'(retired), 64'h7);
    step();
    chk("t4_run", 64'(flushing), 64'h0);

    // Test 5: pc wrap and retired wrap
    beat(6'd15, 4'd0, 64'h0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    idle();
    step();
    chk("t5_pc_max", pc, 64'hFFFF_FFFF_FFFF_FFFF);
    beat(6'd0, 4'd4, 64'h7, 1'b0, 1'b0, 64'h0);
    step();
    idle();
    chk("t5_pc_wrap", pc, 64'h0);
    chk("t5_retired", 64'(retired), 64'h9);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    // Unknown opcode: counts and advances, but no write and no flag change
    beat(6'd20, 4'd5, 64'h99, 1'b1, 1'b0, 64'h0);
    rs_a = 4'd5;
    step();
    idle();
    #1;
    chk("t5_ret_wrap", 64'(retired), 64'h0);
    chk("t5_unk_pc", pc, 64'h1);
    chk("t5_unk_nowr", rd_a, 64'h0);
    chk("t5_unk_flags", 64'({F1, F2}), 64'b01);

    // Jump that also writes reg8: target comes from naddr, not C
    beat(6'd6, 4'd8, 64'h88, 1'b0, 1'b0, 64'h200);
    #1;
    chk("r8_bypass", reg8, 64'h88);
    step();
    idle();
    #1;
    chk("r8_value", reg8, 64'h88);
    chk("r8_pc", pc, 64'h200);
    step();

    // Test 6: asynchronous reset in the middle of a FLUSH cycle
    beat(6'd8, 4'd0, 64'h0, 1'b1, 1'b0, 64'h0);
    step();
    beat(6'd15, 4'd0, 64'h0, 1'b0, 1'b1, 64'h300);
    step();
    idle();
    chk("t6_in_flush", 64'(flushing), 64'h1);
    #2;
    reset = 1'b1;
    #1;
    rs_a = 4'd3;
    #0;
    chk("t6_pc", pc, 64'h0);
    chk("t6_flush", 64'(flushing), 64'h0);
    chk("t6_flags", 64'({F1, F2}), 64'h0);
    chk("t6_retired", 64'(retired), 64'h0);
    chk("t6_reg3", rd_a, 64'h0);
    @(negedge clock);
    reset = 1'b0;
    beat(6'd0, 4'd3, 64'hABC, 1'b0, 1'b0, 64'h0);
    step();
    idle();
    #1;
    chk("t6_post_reg3", rd_a, 64'hABC);
    chk("t6_post_pc", pc, 64'h1);
    chk("t6_post_ret", 64'(retired), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Stage directly downstream of the ALU. It consumes the ALU result C, the condition output F3, and the branch outputs addrch/naddr.
- Owns the architectural state: a 16x64 register file, the F1/F2 flag registers and the program counter.
- Feeds operands, reg8 and the flags back to the ALU inputs.
- After every taken redirect it drops the one wrong-path instruction.

Parameters:
- XLEN, 64, datapath width.
- NREG, 16, number of registers. Index width is log2(NREG) = 4.
- RESET_PC, 0, PC value after reset.
- LINK_REG, 15, register that receives the return address on a call (instr 7).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- valid_in  in  1  ALU beat is present this cycle.
- instr  in  6  opcode of the beat.
- dest  in  4  destination register index.
- C  in  XLEN  ALU result.
- F3  in  1  ALU condition result.
- addrch  in  1  ALU conditional branch taken.
- naddr  in  XLEN  ALU branch target.
- rs_a  in  4  read index for operand A.
- rs_b  in  4  read index for operand B.
- rd_a  out  XLEN  register[rs_a], with write bypass.
- rd_b  out  XLEN  register[rs_b], with write bypass.
- reg8  out  XLEN  register[8], with write bypass.
- F1  out  1  flag register (newest condition).
- F2  out  1  flag register (previous condition).
- pc  out  XLEN  current program counter.
- flushing  out  1  high while in state FLUSH.
- retired  out  32  count of committed beats.

Behaviour:
- Reset (async, immediate):
  - all registers = 0; F1 = F2 = 0; pc = RESET_PC; state = RUN; retired = 0; flushing = 0.
- Accepted beat: valid_in = 1 while state = RUN. All state updates for an accepted beat occur on the next rising edge (1-cycle latency).
- Register write:
  - instr 0, 1, 2, 3, 4, 5, 6, 16, 17: register[dest] <= C.
  - instr 7: register[LINK_REG] <= pc + 1. C is ignored.
  - All other opcodes: no register write.
- Flag update:
  - instr 8 through 13: F2 <= F1; F1 <= F3. Both updates happen in the same edge.
  - All other opcodes: flags hold.
- PC update:
  - Redirect = (addrch = 1) or instr 6 or instr 7.
  - On redirect: pc <= naddr, and state <= FLUSH.
  - Otherwise: pc <= pc + 1, wrapping modulo 2^XLEN.
  - addrch = 1 is honoured for any opcode.
- FSM, two states:
  - RUN: normal operation; flushing = 0.
  - FLUSH: flushing = 1. Lasts exactly one cycle, then returns to RUN unconditionally.
  - A valid_in beat arriving in FLUSH is dropped: no register, flag, pc or retired change.
  - A redirect cannot occur in FLUSH, because the beat is dropped.
- retired counter:
  - Increments by 1 on every accepted beat, including non-writing opcodes.
  - Wraps at 2^32.
- Read ports:
  - Combinational.
  - If an accepted beat is writing register N this cycle and a read index equals N, the output presents the write data, not the stored value. This applies to rd_a, rd_b and reg8.
  - For instr 7 the bypass data is pc + 1.
- Simultaneous events:
  - Read and write to the same register in one cycle: bypass applies.
  - instr 7 with addrch = 1: one redirect to naddr, plus the link write.
  - Write to register 8 by a redirecting beat: the redirect uses the naddr input, not the new reg8.
- Reset mid-FLUSH: returns to RUN immediately; the drop is cancelled.
- Unknown opcodes (18 through 63):
  - Accepted; pc + 1 and retired + 1.
  - No register write and no flag change.
  - Redirect only if addrch = 1.

Test Plan:
1. Reset, then beat instr = 0, dest = 3, C = 0x1234.
   - Next cycle: register3 = 0x1234; pc = 1; retired = 1.
   - Bypass check in the write cycle: with rs_a = 3, rd_a = 0x1234.
2. Beats instr 8 with F3 = 1, then instr 9 with F3 = 0.
   - After the first: F1 = 1, F2 = 0.
   - After the second: F1 = 0, F2 = 1.
   - An instr 0 beat afterwards leaves both flags unchanged.
3. Beat instr = 15, addrch = 1, naddr = 0x40, then a valid beat instr = 0, dest = 2, C = 0x55.
   - pc = 0x40 and flushing = 1 for one cycle.
   - The second beat is dropped: register2 stays 0 and retired does not increment.
   - RUN resumes the following cycle.
4. With pc = 0x10, beat instr = 7, naddr = 0x80.
   - register15 = 0x11; pc = 0x80; one flush cycle follows.
5. With pc = 0xFFFF_FFFF_FFFF_FFFF, beat instr = 0.
   - pc wraps to 0.
   - Separately, preload retired = 0xFFFF_FFFF; after one accepted beat retired = 0.
6. Assert reset asynchronously during FLUSH, mid-cycle.
   - Outputs clear immediately: pc = RESET_PC, flushing = 0, F1 = F2 = 0.
   - The first beat after reset release is accepted normally.
